// File: rtl/caliptra_prim_rr_lock_arb.sv
// caliptra_prim_rr_lock_arb: round-robin lock arbiter (clk_i/rst_i/en_i/req_i in; gnt_o, gnt_idx_o, gnt_valid_o, timeout_o, busy_o out)
module caliptra_prim_rr_lock_arb #(
  parameter int NumReq = 4,
  parameter int MaxHold = 255,
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CntW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o,
  output logic              timeout_o,
  output logic              busy_o
);
  localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2;
  logic [1:0] state;
  logic [IdxW-1:0] idx, ptr, pick, nxt_ptr;
  logic [CntW-1:0] cnt;
  logic tmo, rel, expire;
  always_comb begin
    pick = '0;
    for (int k = NumReq - 1; k >= 0; k--)
      if (req_i[IdxW'((int'(ptr) + k) % NumReq)]) pick = IdxW'((int'(ptr) + k) % NumReq);
  end
  assign rel = !req_i[idx];
  assign expire = (MaxHold != 0) && (cnt == CntW'(MaxHold - 1));
  assign nxt_ptr = (idx == IdxW'(NumReq - 1)) ? '0 : idx + IdxW'(1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      tmo <= 1'b0;
      if (state == IDLE && en_i && |req_i) begin
        state <= GRANT;
        idx <= pick;
        cnt <= '0;
      end else if (state == GRANT && (rel || expire)) begin
        state <= GAP;
        ptr <= nxt_ptr;
        tmo <= !rel;
      end else if (state == GRANT) begin
        cnt <= (cnt == CntW'(MaxHold)) ? cnt : cnt + CntW'(1);
      end else if (state == GAP) begin
        state <= IDLE;
      end
    end
  end
  assign gnt_valid_o = state == GRANT;
  assign gnt_o = gnt_valid_o ? NumReq'(1) << idx : '0;
  assign gnt_idx_o = gnt_valid_o ? idx : '0;
  assign timeout_o = tmo;
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_caliptra_prim_rr_lock_arb.sv
// tb_caliptra_prim_rr_lock_arb: randomized and directed check of the lock arbiter against a behavioural model
module tb_caliptra_prim_rr_lock_arb;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [3:0] req_a = '0, gnt_a;
  logic [2:0] req_b = '0, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic val_a, val_b, tmo_a, tmo_b, busy_a, busy_b;
  int n_chk = 0, n_err = 0;
  typedef struct {int owner; int held; bit gap; bit tmo; int ptr;} ms_t;
  ms_t ma, mb;
  always #5 clk = ~clk;
  caliptra_prim_rr_lock_arb #(.NumReq(4), .MaxHold(5)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req_a), .gnt_o(gnt_a),
    .gnt_idx_o(idx_a), .gnt_valid_o(val_a), .timeout_o(tmo_a), .busy_o(busy_a));
  caliptra_prim_rr_lock_arb #(.NumReq(3), .MaxHold(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req_b), .gnt_o(gnt_b),
    .gnt_idx_o(idx_b), .gnt_valid_o(val_b), .timeout_o(tmo_b), .busy_o(busy_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic ms_t step(ms_t s, int n, int mh, logic r, logic e, logic [31:0] q);
    ms_t t = s;
    t.tmo = 1'b0;
    if (r) begin
      t.owner = -1; t.held = 0; t.gap = 1'b0; t.ptr = 0;
    end else if (s.owner >= 0) begin
      t.held = s.held + 1;
      if (!q[s.owner] || (mh != 0 && t.held == mh)) begin
        t.tmo = q[s.owner]; t.gap = 1'b1; t.ptr = (s.owner + 1) % n; t.owner = -1;
      end
    end else if (s.gap) begin
      t.gap = 1'b0;
    end else if (e && q != 0) begin
      for (int k = 0; k < n; k++)
        if (t.owner < 0 && q[(s.ptr + k) % n]) t.owner = (s.ptr + k) % n;
      t.held = 0;
    end
    return t;
  endfunction
  function automatic logic [31:0] one(int o);
    return (o >= 0) ? (32'd1 << o) : 32'd0;
  endfunction
  task automatic tick(input logic r, input logic e, input logic [3:0] qa, input logic [2:0] qb);
    @(negedge clk);
    rst = r; en = e; req_a = qa; req_b = qb;
    @(posedge clk);
    ma = step(ma, 4, 5, r, e, {28'd0, qa});
    mb = step(mb, 3, 0, r, e, {29'd0, qb});
    #1;
    chk("a_gnt", 32'(gnt_a), one(ma.owner));
    chk("a_idx", 32'(idx_a), (ma.owner >= 0) ? ma.owner : 0);
    chk("a_val", 32'(val_a), 32'(ma.owner >= 0));
    chk("a_tmo", 32'(tmo_a), 32'(ma.tmo));
    chk("a_busy", 32'(busy_a), 32'(ma.owner >= 0 || ma.gap));
    chk("b_gnt", 32'(gnt_b), one(mb.owner));
    chk("b_idx", 32'(idx_b), (mb.owner >= 0) ? mb.owner : 0);
    chk("b_val", 32'(val_b), 32'(mb.owner >= 0));
    chk("b_tmo", 32'(tmo_b), 32'(mb.tmo));
    chk("b_busy", 32'(busy_b), 32'(mb.owner >= 0 || mb.gap));
  endtask
  initial begin
    logic [3:0] qa;
    logic [2:0] qb;
    ma = '{-1, 0, 1'b0, 1'b0, 0};
    mb = '{-1, 0, 1'b0, 1'b0, 0};
    tick(1, 1, 4'b0000, 3'b000);
    chk("rst_gnt", 32'(gnt_a), 0);
    tick(0, 1, 4'b1010, 3'b100);
    chk("first_gnt", 32'(gnt_a), 32'b0010);
    chk("first_idx", 32'(idx_a), 1);
    chk("b_own2", 32'(gnt_b), 32'b100);
    tick(0, 1, 4'b1000, 3'b011);
    chk("gap_gnt", 32'(gnt_a), 0);
    chk("gap_busy", 32'(busy_a), 1);
    tick(0, 1, 4'b1000, 3'b011);
    tick(0, 1, 4'b1000, 3'b011);
    chk("next_gnt", 32'(gnt_a), 32'b1000);
    chk("wrap_gnt", 32'(gnt_b), 32'b001);
    tick(0, 1, 4'b0100, 3'b000);
    tick(0, 1, 4'b0100, 3'b000);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 4'b0100, 3'b000);
      chk("hold_gnt", 32'(gnt_a), 32'b0100);
    end
    tick(0, 1, 4'b0100, 3'b000);
    chk("to_pulse", 32'(tmo_a), 1);
    chk("to_gnt", 32'(gnt_a), 0);
    tick(0, 1, 4'b0100, 3'b000);
    chk("to_pulse_end", 32'(tmo_a), 0);
    tick(0, 1, 4'b0100, 3'b000);
    chk("regrant", 32'(gnt_a), 32'b0100);
    tick(0, 1, 4'b0000, 3'b000);
    tick(0, 1, 4'b1001, 3'b000);
    tick(0, 1, 4'b1001, 3'b000);
    chk("own3", 32'(gnt_a), 32'b1000);
    tick(1, 1, 4'b1001, 3'b000);
    chk("rst_drop", 32'(gnt_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    tick(0, 1, 4'b1001, 3'b000);
    chk("rst_low", 32'(gnt_a), 32'b0001);
    tick(0, 0, 4'b1001, 3'b000);
    tick(0, 0, 4'b1001, 3'b000);
    chk("en_keep", 32'(gnt_a), 32'b0001);
    tick(0, 0, 4'b1000, 3'b000);
    for (int i = 0; i < 3; i++) tick(0, 0, 4'b1000, 3'b000);
    chk("en_block", 32'(gnt_a), 0);
    tick(0, 1, 4'b1000, 3'b000);
    chk("en_resume", 32'(gnt_a), 32'b1000);
    tick(1, 1, 4'b0000, 3'b000);
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 4'b1111, 3'b111);
      chk("rr_order", 32'(gnt_a), 32'd1 << (k % 4));
      tick(0, 1, 4'b1111, 3'b111);
      tick(0, 1, 4'b1111, 3'b111);
      tick(0, 1, 4'b1111 & ~(4'd1 << (k % 4)), 3'b111);
      chk("rr_gap", 32'(gnt_a), 0);
      tick(0, 1, 4'b1111, 3'b111);
      chk("rr_idle", 32'(gnt_a), 0);
    end
    for (int i = 0; i < 800; i++) begin
      qa = 4'($urandom);
      qb = 3'($urandom);
      if (ma.owner >= 0) qa[ma.owner] = ($urandom_range(0, 7) != 0);
      if (mb.owner >= 0) qb[mb.owner] = ($urandom_range(0, 7) != 0);
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, qa, qb);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
